// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter
module bin_to_bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int SCR_W = 4 * DIGITS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [SCR_W-1:0]   scratch_q;
  logic               ovf_q;
  logic [CNT_W-1:0]   count_q;

  logic [SCR_W-1:0]   adj_d;
  logic [SCR_W-1:0]   scratch_d;
  logic [BIN_W-1:0]   shift_d;
  logic               ovf_d;
  logic [DIGITS-1:0]  lz_d;

  // One conversion step: correct digits >= 5, then shift the next binary bit in.
  // A 1 leaving the top digit means the value no longer fits in DIGITS digits.
  always_comb begin
    adj_d = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_d = {adj_d[SCR_W-2:0], shift_q[BIN_W-1]};
    shift_d   = shift_q << 1;
    ovf_d     = ovf_q | adj_d[SCR_W-1];
  end

  // Leading-zero mask of the post-shift scratch; the ones digit is never blanked.
  always_comb begin
    logic zero_above;
    lz_d       = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (scratch_d[4*i +: 4] == 4'd0);
      lz_d[i]    = zero_above;
    end
  end

  // Control FSM with registered outputs; results only change on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
      lz_mask   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q   <= bin_in;
            scratch_q <= '0;
            ovf_q     <= 1'b0;
            count_q   <= CNT_W'(BIN_W);
            busy      <= 1'b1;
            state_q   <= S_CONV;
          end
        end
        S_CONV: begin
          scratch_q <= scratch_d;
          shift_q   <= shift_d;
          ovf_q     <= ovf_d;
          count_q   <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            bcd_out  <= scratch_d;
            overflow <= ovf_d;
            lz_mask  <= lz_d;
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - directed self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

  logic clk;
  logic reset;

  logic        start_a, start_b, start_c;
  logic [15:0] bin_a, bin_b;
  logic [7:0]  bin_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [19:0] bcd_a;
  logic [15:0] bcd_b;
  logic [11:0] bcd_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [4:0]  lz_a;
  logic [3:0]  lz_b;
  logic [2:0]  lz_c;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;

  logic        cur_busy, cur_done, cur_ovf;
  logic [31:0] cur_bcd, cur_lz;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a), .overflow(ovf_a), .lz_mask(lz_a)
  );

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b), .overflow(ovf_b), .lz_mask(lz_b)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .bin_in(bin_c),
    .busy(busy_c), .done(done_c), .bcd_out(bcd_c), .overflow(ovf_c), .lz_mask(lz_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation mux over the instance under test
  always_comb begin
    cur_busy = busy_a;
    cur_done = done_a;
    cur_ovf  = ovf_a;
    cur_bcd  = {12'd0, bcd_a};
    cur_lz   = {27'd0, lz_a};
    case (sel)
      1: begin
        cur_busy = busy_b; cur_done = done_b; cur_ovf = ovf_b;
        cur_bcd  = {16'd0, bcd_b}; cur_lz = {28'd0, lz_b};
      end
      2: begin
        cur_busy = busy_c; cur_done = done_c; cur_ovf = ovf_c;
        cur_bcd  = {20'd0, bcd_c}; cur_lz = {29'd0, lz_c};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [31:0] v);
    case (sel)
      0: begin start_a = s; bin_a = v[15:0]; end
      1: begin start_b = s; bin_b = v[15:0]; end
      default: begin start_c = s; bin_c = v[7:0]; end
    endcase
  endtask

  // Waits up to max cycles for done; n returns cycles waited
  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!cur_done && n < max);
    check("done_seen", {31'd0, cur_done}, 32'd1);
  endtask

  // One full conversion from idle with latency, busy-width and pulse-width checks
  task automatic conv(input string tag, input logic [31:0] v, input logic [31:0] exp_bcd,
                      input logic exp_ovf, input logic [31:0] exp_lz, input int lat);
    int n;
    int busy_cnt;
    @(posedge clk); #1;
    drive(1'b1, v);
    @(posedge clk); #1;
    drive(1'b0, $urandom);
    busy_cnt = 0;
    n = 0;
    do begin
      if (cur_busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end while (!cur_done && n < lat + 5);
    check({tag, "_done"}, {31'd0, cur_done}, 32'd1);
    check({tag, "_lat"}, n, lat);
    check({tag, "_busy_cycles"}, busy_cnt, lat);
    check({tag, "_bcd"}, cur_bcd, exp_bcd);
    check({tag, "_ovf"}, {31'd0, cur_ovf}, {31'd0, exp_ovf});
    check({tag, "_lz"}, cur_lz, exp_lz);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, cur_done}, 32'd0);
    check({tag, "_hold"}, cur_bcd, exp_bcd);
  endtask

  initial begin
    int n;
    int cnt;
    int t[3];
    logic [31:0] eb;
    logic [31:0] el;

    reset = 1'b1;
    start_a = 0; start_b = 0; start_c = 0;
    bin_a = 0; bin_b = 0; bin_c = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_bcd", {12'd0, bcd_a}, 32'd0);
    check("rst_ovf", {31'd0, ovf_a}, 32'd0);
    check("rst_lz", {27'd0, lz_a}, 32'd0);
    reset = 1'b0;

    // 16-bit / 5 digits
    sel = 0;
    conv("a65535", 65535, 32'h65535, 1'b0, 32'b00000, 16);
    conv("a1234", 1234, 32'h01234, 1'b0, 32'b10000, 16);
    conv("a0", 0, 32'h00000, 1'b0, 32'b11110, 16);

    // 16-bit / 4 digits: overflow then sticky flag cleared
    sel = 1;
    conv("b12345", 12345, 32'h2345, 1'b1, 32'b0000, 16);
    conv("b9999", 9999, 32'h9999, 1'b0, 32'b0000, 16);

    // start while busy is ignored
    sel = 0;
    @(posedge clk); #1;
    drive(1'b1, 500);
    @(posedge clk); #1;
    drive(1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    drive(1'b1, 777);
    @(posedge clk); #1;
    drive(1'b0, 0);
    wait_done(30, n);
    check("ign_lat", n + 5, 16);
    check("ign_bcd", cur_bcd, 32'h00500);
    check("ign_lz", cur_lz, 32'b11000);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (cur_done) cnt++;
    end
    check("ign_no_extra_done", cnt, 0);

    // start held high: one result every BIN_W+1 cycles
    @(posedge clk); #1;
    drive(1'b1, 1);
    cnt = 0;
    for (int i = 1; i <= 80 && cnt < 3; i++) begin
      @(posedge clk); #1;
      if (cur_done) begin
        t[cnt] = i;
        cnt++;
      end
    end
    check("held_done_count", cnt, 3);
    check("held_interval1", t[1] - t[0], 17);
    check("held_interval2", t[2] - t[1], 17);
    check("held_bcd", cur_bcd, 32'h00001);
    drive(1'b0, 0);
    n = 0;
    while (cur_busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_drain_idle", {31'd0, cur_busy}, 32'd0);
    repeat (2) @(posedge clk);

    // reset mid-conversion aborts; start on the reset edge is ignored
    @(posedge clk); #1;
    drive(1'b1, 4321);
    @(posedge clk); #1;
    drive(1'b0, 0);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 4321);
    @(posedge clk); #1;
    check("rstmid_busy", {31'd0, cur_busy}, 32'd0);
    check("rstmid_done", {31'd0, cur_done}, 32'd0);
    check("rstmid_bcd", cur_bcd, 32'd0);
    check("rstmid_ovf", {31'd0, cur_ovf}, 32'd0);
    check("rstmid_lz", cur_lz, 32'd0);
    reset = 1'b0;
    drive(1'b0, 0);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (cur_done || cur_busy) cnt++;
    end
    check("rstmid_quiet", cnt, 0);
    conv("a42", 42, 32'h00042, 1'b0, 32'b11100, 16);

    // 8-bit / 3 digits full sweep against a decimal model
    sel = 2;
    for (int v = 0; v < 256; v++) begin
      eb = ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
      el = 0;
      if (v < 100) el[2] = 1'b1;
      if (v < 10)  el[1] = 1'b1;
      conv($sformatf("c%0d", v), v, eb, 1'b0, el, 8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock.
- Replaces the fixed 16-bit, 4-digit combinational divide/modulo converter that feeds the seven-segment display path.
- Runs without dividers, supports any input width and digit count, and provides a start/busy/done handshake, an overflow flag and a leading-zero mask for display blanking.

Parameters:
- BIN_W, 16, width of the binary input in bits (minimum 1).
- DIGITS, 5, number of BCD digits produced (minimum 1). 5 covers the full 16-bit range.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when busy=0.
- bin_in  input  BIN_W  unsigned binary operand; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd_out, overflow and lz_mask are valid and updated in the same cycle.
- bcd_out  output  4*DIGITS  result; digit i occupies bits [4i+3:4i], digit 0 is the ones digit.
- overflow  output  1  bin_in exceeded 10^DIGITS-1 for the last conversion.
- lz_mask  output  DIGITS  bit i=1 when digit i is a leading zero. Bit 0 is always 0.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Port names are clk and reset.
- Reset values: busy=0, done=0, bcd_out=0, overflow=0, lz_mask=0; FSM in IDLE; internal shift, scratch and count registers cleared.
- FSM states:
  - IDLE: when start=1 at an edge, latch bin_in into the shift register, clear the BCD scratch and overflow scratch, load count=BIN_W, and go to CONV. busy=1 from the next cycle.
  - CONV: at each edge, first add 3 to every scratch digit that is >=5. Then shift {scratch, shift register} left by one; the shift register MSB enters scratch bit 0. Decrement count.
  - CONV exit: the edge on which count reaches 0 (the BIN_W-th shift) loads bcd_out from the post-shift scratch, sets overflow and lz_mask, pulses done=1 for exactly one cycle, sets busy=0, and returns to IDLE.
- Latency:
  - start sampled at edge k; done=1 in the cycle following edge k+BIN_W.
  - Back-to-back conversions are allowed: start=1 during the done cycle is accepted, giving one result per BIN_W+1 cycles.
- start handling: start while busy=1 is ignored; no queuing, and bin_in is not re-sampled. Holding start high continuously produces repeated conversions.
- Overflow:
  - A sticky scratch bit is set if a 1 is shifted out of the MSB of the top digit during any CONV cycle.
  - On overflow, bcd_out holds the value mod 10^DIGITS, i.e. the low DIGITS decimal digits.
  - overflow cannot occur when 10^DIGITS > 2^BIN_W-1; synthesis may then tie it to 0.
- Leading-zero mask:
  - lz_mask[i]=1 iff digit i and all digits above it are 0, for i>=1.
  - lz_mask[0]=0 always, so a value of 0 displays a single "0".
- Output hold: bcd_out, overflow and lz_mask hold until the next done pulse or reset. They never show partial results.
- Reset mid-conversion: abort immediately; all outputs return to reset values; no done pulse. A start asserted on the reset edge is ignored.
- bin_in changes during CONV have no effect.

Test Plan:
- BIN_W=16, DIGITS=5, bin_in=65535 with a one-cycle start -> busy high 16 cycles; done 16 cycles after the start edge; bcd_out=0x65535, overflow=0, lz_mask=5'b00000.
- bin_in=1234 -> bcd_out=0x01234, lz_mask=5'b10000. Then bin_in=0 -> bcd_out=0x00000, lz_mask=5'b11110, overflow=0.
- BIN_W=16, DIGITS=4: bin_in=12345 -> bcd_out=0x2345, overflow=1. Then bin_in=9999 -> bcd_out=0x9999, overflow=0, and the sticky flag is cleared.
- start pulse with bin_in=500, then start re-asserted with bin_in=777 at cycle 5 while busy -> ignored; single done with bcd_out=0x00500. Next, start held high -> successive done pulses exactly 17 cycles apart.
- bin_in=4321 conversion with reset asserted at cycle 7 -> no done pulse; next cycle busy=0, bcd_out=0, overflow=0, lz_mask=0. A fresh start with bin_in=42 then yields 0x00042.
- BIN_W=8, DIGITS=3 sweep of bin_in 0..255 -> every bcd_out matches the decimal reference model, overflow=0 throughout, done latency 8 cycles.
